sync_fifos: RTL and testbench
=============================

// Module: sync_fifos
// PURPOSE
//  Single-clock first-in/first-out buffer, 256 words x 16 bits, used as general elastic storage between producer/consumer logic in one clock domain.
//  Provides full, empty, almost-full and almost-empty flags, a fill-level count and a synchronous clear.
//  Reads use normal (non-show-ahead) mode: q updates one clock after a read is accepted.
// PARAMETERS
//  DATA_W           16   data word width
//  DEPTH            256  number of words (power of two)
//  ADDR_W           8    log2(DEPTH); also width of usedw
//  ALMOST_FULL_VAL  240  almost_full asserts when stored count >= this value
//  ALMOST_EMPTY_VAL 16   almost_empty asserts when stored count < this value
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  data          in   DATA_W  write data
//  wrreq         in   1       write request
//  rdreq         in   1       read request
//  sclr          in   1       synchronous clear, active-high
//  q             out  DATA_W  read data (registered)
//  usedw         out  ADDR_W  stored word count modulo DEPTH
//  full          out  1       DEPTH words stored
//  empty         out  1       zero words stored
//  almost_full   out  1       count >= ALMOST_FULL_VAL
//  almost_empty  out  1       count < ALMOST_EMPTY_VAL
// BEHAVIOUR
//  - Internal count is ADDR_W+1 bits (0..DEPTH). usedw = count[ADDR_W-1:0], so it reads 0 when full=1.
//  - All flags are registered and derived from the count, so they reflect the state after the last clock edge.
//  - rst low (async): pointers=0, count=0, q=0, empty=1, almost_empty=1, full=0, almost_full=0.
//  - sclr=1 at an edge: same state as reset, synchronously. Overrides wrreq/rdreq in that cycle.
//  - Write accepted = wrreq & ~full. data is stored at wr_ptr and wr_ptr increments (wraps DEPTH-1 -> 0).
//  - Read accepted = rdreq & ~empty. q <= mem[rd_ptr] at that edge (1-cycle latency). rd_ptr increments and wraps.
//  - With no accepted read, q holds its value.
//  - Overflow protection: wrreq while full is ignored, even if rdreq is set in the same cycle.
//  - Underflow protection: rdreq while empty is ignored; q holds.
//  - Both accepted in one cycle: count unchanged and both pointers advance.
//  - Write-only accepted: count+1. Read-only accepted: count-1.
//  - Data ordering is strictly FIFO. No read-during-write bypass is needed, because a read never targets the word being written.
// CONFIGURATION
//  - Macro FIFOS_ERR_FLAGS_EN defined: adds output ports overflow (1) and underflow (1).
//    - overflow is a sticky flag set when wrreq arrives while full.
//    - underflow is a sticky flag set when rdreq arrives while empty.
//    - Both are cleared by rst or sclr.
//  - Macro not defined: these ports and their logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package fifos_pkg: DATA_W, DEPTH, ADDR_W constants and the default almost thresholds.
//  - One sub-module, fifos_ram: simple dual-port RAM with synchronous write and synchronous registered read (DEPTH x DATA_W).
//    - It supplies q.
//    - The reset/sclr clear of q is applied on the output register in the top level.
//  - Top level holds the pointers, count, flag registers and accept logic.
// TESTING
//  1. Reset: hold rst=0 for 20 cycles -> empty=1, almost_empty=1, full=0, almost_full=0, usedw=0, q=0.
//  2. Fill: write data=0..255 on consecutive cycles.
//     - almost_empty falls after the 16th write.
//     - almost_full rises after the 240th write.
//     - After the 256th write: full=1, usedw=0, empty=0.
//  3. Overflow: with the FIFO full, wrreq=1, data=16'hBEEF -> count unchanged, word not stored; overflow=1 when FIFOS_ERR_FLAGS_EN is defined.
//  4. Drain: 256 consecutive rdreq -> q=0,1,...,255, each one cycle after its read.
//     - Afterwards empty=1, usedw=0, and q stays 255.
//     - An extra rdreq leaves q=255 and sets underflow when the macro is defined.
//  5. Simultaneous: with 5 words held, assert wrreq and rdreq together for 10 cycles -> usedw stays 5 and q follows FIFO order.
//  6. Clear: sclr=1 mid-fill (usedw=100) together with wrreq -> next cycle usedw=0, empty=1, q=0, nothing written.

Source files
------------

// File: rtl/fifos_pkg.sv
// fifos_pkg: geometry and flag thresholds shared by the sync_fifos block.
package fifos_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH = 256;
  localparam int ADDR_W = 8;
  localparam int ALMOST_FULL_VAL = 240;
  localparam int ALMOST_EMPTY_VAL = 16;
endpackage

// File: rtl/fifos_ram.sv
// fifos_ram: simple dual-port RAM, synchronous write and registered synchronous read.
module fifos_ram
  import fifos_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/sync_fifos.sv
// sync_fifos: 256x16 single-clock FIFO with registered flags and fill count.
// Defining FIFOS_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifos
  import fifos_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  input  logic              sclr,
`ifdef FIFOS_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] usedw,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] cnt, cnt_nx;
  logic [DATA_W-1:0] ram_q;
  logic wr_ok, rd_ok, q_vld;
  assign wr_ok = wrreq & ~full & ~sclr;
  assign rd_ok = rdreq & ~empty & ~sclr;
  always_comb cnt_nx = cnt + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};
  fifos_ram u_ram (
    .clk(clk), .we(wr_ok), .wa(wr_ptr), .wd(data),
    .re(rd_ok), .ra(rd_ptr), .rd(ram_q)
  );
  // RAM output register can't be reset, so q is masked until the first read after a clear
  assign q = q_vld ? ram_q : '0;
  assign usedw = cnt[ADDR_W-1:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      q_vld <= 1'b0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      q_vld <= 1'b0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr_ok);
      rd_ptr <= rd_ptr + ADDR_W'(rd_ok);
      cnt <= cnt_nx;
      q_vld <= q_vld | rd_ok;
      full <= cnt_nx == (ADDR_W+1)'(DEPTH);
      empty <= cnt_nx == '0;
      almost_full <= cnt_nx >= (ADDR_W+1)'(ALMOST_FULL_VAL);
      almost_empty <= cnt_nx < (ADDR_W+1)'(ALMOST_EMPTY_VAL);
    end
  end
`ifdef FIFOS_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (sclr) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= overflow | (wrreq & full);
      underflow <= underflow | (rdreq & empty);
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifos.sv
// tb_sync_fifos: directed self-checking bench for sync_fifos.
module tb_sync_fifos;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] data = '0;
  logic wrreq = 1'b0, rdreq = 1'b0, sclr = 1'b0;
  logic [15:0] q;
  logic [7:0] usedw;
  logic full, empty, almost_full, almost_empty;
`ifdef FIFOS_ERR_FLAGS_EN
  logic overflow, underflow;
`endif
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sync_fifos dut (
    .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .rdreq(rdreq), .sclr(sclr),
`ifdef FIFOS_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .q(q), .usedw(usedw), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (20) tick;
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_usedw", 32'(usedw), 0);
    check("rst_q", 32'(q), 0);
    rst = 1'b1;
    tick;
    for (int i = 0; i < 256; i++) begin
      data = 16'(i);
      wrreq = 1'b1;
      tick;
      check("fill_usedw", 32'(usedw), 32'((i + 1) % 256));
      check("fill_aempty", 32'(almost_empty), 32'(i + 1 < 16));
      check("fill_afull", 32'(almost_full), 32'(i + 1 >= 240));
      check("fill_full", 32'(full), 32'(i + 1 == 256));
      check("fill_empty", 32'(empty), 0);
    end
    data = 16'hBEEF;
    tick;
    wrreq = 1'b0;
    check("ovf_full", 32'(full), 1);
    check("ovf_usedw", 32'(usedw), 0);
`ifdef FIFOS_ERR_FLAGS_EN
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_noudf", 32'(underflow), 0);
`endif
    for (int i = 0; i < 256; i++) begin
      rdreq = 1'b1;
      tick;
      check("drain_q", 32'(q), 32'(i));
      check("drain_usedw", 32'(usedw), 32'(255 - i));
      check("drain_empty", 32'(empty), 32'(i == 255));
      check("drain_full", 32'(full), 0);
      check("drain_aempty", 32'(almost_empty), 32'(255 - i < 16));
    end
    tick;
    rdreq = 1'b0;
    check("udf_q", 32'(q), 255);
    check("udf_empty", 32'(empty), 1);
    check("udf_usedw", 32'(usedw), 0);
`ifdef FIFOS_ERR_FLAGS_EN
    check("udf_flag", 32'(underflow), 1);
    check("ovf_sticky", 32'(overflow), 1);
`endif
    for (int k = 0; k < 5; k++) begin
      data = 16'(100 + k);
      wrreq = 1'b1;
      tick;
    end
    check("sim_pre_usedw", 32'(usedw), 5);
    for (int k = 0; k < 10; k++) begin
      data = 16'(200 + k);
      wrreq = 1'b1;
      rdreq = 1'b1;
      tick;
      check("sim_usedw", 32'(usedw), 5);
      check("sim_q", 32'(q), k < 5 ? 32'(100 + k) : 32'(200 + k - 5));
    end
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr = 1'b1;
    tick;
    sclr = 1'b0;
    check("clr1_q", 32'(q), 0);
    check("clr1_empty", 32'(empty), 1);
    check("clr1_usedw", 32'(usedw), 0);
`ifdef FIFOS_ERR_FLAGS_EN
    check("clr1_ovf", 32'(overflow), 0);
    check("clr1_udf", 32'(underflow), 0);
`endif
    for (int i = 0; i < 101; i++) begin
      data = 16'(1000 + i);
      wrreq = 1'b1;
      tick;
    end
    wrreq = 1'b0;
    rdreq = 1'b1;
    tick;
    rdreq = 1'b0;
    check("mid_q", 32'(q), 1000);
    check("mid_usedw", 32'(usedw), 100);
    check("mid_aempty", 32'(almost_empty), 0);
    sclr = 1'b1;
    wrreq = 1'b1;
    data = 16'hDEAD;
    tick;
    sclr = 1'b0;
    wrreq = 1'b0;
    check("clr2_usedw", 32'(usedw), 0);
    check("clr2_empty", 32'(empty), 1);
    check("clr2_aempty", 32'(almost_empty), 1);
    check("clr2_q", 32'(q), 0);
    check("clr2_full", 32'(full), 0);
    rdreq = 1'b1;
    tick;
    rdreq = 1'b0;
    check("clr2_nowrite_q", 32'(q), 0);
    check("clr2_nowrite_empty", 32'(empty), 1);
    data = 16'h7777;
    wrreq = 1'b1;
    tick;
    wrreq = 1'b0;
    check("post_usedw", 32'(usedw), 1);
    rdreq = 1'b1;
    tick;
    rdreq = 1'b0;
    check("post_q", 32'(q), 32'h7777);
    check("post_empty", 32'(empty), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
